// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: sub-word load extraction and read-modify-write sub-word stores
// against a word-wide data memory with combinational reads.
module load_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        access_fault,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] read_address,
   output logic [31:0] Write_data,
   input  logic [31:0] MemData_out
);

   typedef enum logic {StIdle, StMerge} state_e;

   state_e      state_q, state_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] cap_addr_q, cap_addr_d;
   logic        cap_half_q, cap_half_d;
   logic [15:0] cap_data_q, cap_data_d;
   logic [31:0] load_data_q, load_data_d;
   logic        load_valid_q, load_valid_d;
   logic        access_fault_q, access_fault_d;

   logic        is_half, is_word, legal, misaligned, req_ok;
   logic [31:0] shifted, load_ext;
   logic [4:0]  lane_shamt;
   logic [31:0] lane_mask, merged;

   always_comb begin
      is_half    = (funct3[1:0] == 2'b01);
      is_word    = (funct3[1:0] == 2'b10);
      // Stores: 000/001/010 only. Loads: additionally 100/101.
      legal      = req_write ? (!funct3[2] && funct3[1:0] != 2'b11)
                             : (funct3[1:0] != 2'b11 && !(funct3[2] && funct3[1]));
      misaligned = (is_half && addr[0]) || (is_word && addr[1:0] != 2'b00);
      req_ok     = legal && !misaligned;

      shifted = MemData_out >> {addr[1:0], 3'b000};
      case (funct3)
         3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_ext = {24'h0, shifted[7:0]};
         3'b101:  load_ext = {16'h0, shifted[15:0]};
         default: load_ext = shifted;
      endcase

      lane_shamt = {cap_addr_q[1:0], 3'b000};
      lane_mask  = (cap_half_q ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shamt;
      merged     = (merge_q & ~lane_mask) | (({16'h0, cap_data_q} << lane_shamt) & lane_mask);
   end

   always_comb begin
      state_d        = state_q;
      merge_d        = merge_q;
      cap_addr_d     = cap_addr_q;
      cap_half_d     = cap_half_q;
      cap_data_d     = cap_data_q;
      load_data_d    = load_data_q;
      load_valid_d   = 1'b0;
      access_fault_d = 1'b0;
      MemRead        = 1'b0;
      MemWrite       = 1'b0;
      stall          = 1'b0;
      read_address   = {addr[31:2], 2'b00};
      Write_data     = store_data;

      case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (!req_ok) begin
                  access_fault_d = 1'b1;
               end else if (!req_write) begin
                  MemRead      = 1'b1;
                  load_data_d  = load_ext;
                  load_valid_d = 1'b1;
               end else if (is_word) begin
                  MemWrite = 1'b1;
               end else begin
                  MemRead    = 1'b1;
                  stall      = 1'b1;
                  merge_d    = MemData_out;
                  cap_addr_d = addr;
                  cap_half_d = is_half;
                  cap_data_d = store_data[15:0];
                  state_d    = StMerge;
               end
            end
         end
         StMerge: begin
            // Request inputs are ignored here; only the captured fields are used.
            read_address = {cap_addr_q[31:2], 2'b00};
            Write_data   = merged;
            MemWrite     = 1'b1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Reset aborts any pending merge write in the same cycle.
      if (reset) begin
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         stall    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         merge_q        <= '0;
         cap_addr_q     <= '0;
         cap_half_q     <= 1'b0;
         cap_data_q     <= '0;
         load_data_q    <= '0;
         load_valid_q   <= 1'b0;
         access_fault_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         merge_q        <= merge_d;
         cap_addr_q     <= cap_addr_d;
         cap_half_q     <= cap_half_d;
         cap_data_q     <= cap_data_d;
         load_data_q    <= load_data_d;
         load_valid_q   <= load_valid_d;
         access_fault_q <= access_fault_d;
      end
   end

   assign load_data    = load_data_q;
   assign load_valid   = load_valid_q;
   assign access_fault = access_fault_q;

endmodule
